// File: rtl/timer_pkg.sv
// ============================================================================
// Module : timer_pkg
// Brief  : Shared types and defaults for the stopwatch run/pause sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVF   = 2'd3
    } timer_state_t;

    localparam int TICK_DIV_DEFAULT = 50_000_000;
    localparam int LAP_W_DEFAULT    = 4;

endpackage : timer_pkg

`default_nettype wire

// File: rtl/timer_ctrl_if.sv
// ============================================================================
// Module : timer_ctrl_if
// Brief  : Button/status bundle between user inputs, timer_ctrl and the counter chain.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface timer_ctrl_if #(
    parameter int LAP_W = 4
);
    logic             start_stop;
    logic             clear;
    logic             sec_tc;
    logic             min_tc;
    logic             lap;
    logic             sec_en;
    logic             min_en;
    logic             cnt_clr;
    logic             running;
    logic             ovf;
    logic             lap_hold;
    logic [LAP_W-1:0] lap_cnt;

    modport master (
        output start_stop, clear, sec_tc, min_tc, lap,
        input  sec_en, min_en, cnt_clr, running, ovf, lap_hold, lap_cnt
    );

    modport slave (
        input  start_stop, clear, sec_tc, min_tc, lap,
        output sec_en, min_en, cnt_clr, running, ovf, lap_hold, lap_cnt
    );

endinterface : timer_ctrl_if

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module : tick_prescaler
// Brief  : Divides clk down to a one-cycle count tick; holds its phase when not running.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_prescaler
    import timer_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int               PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          at_max;

    assign at_max = (presc_q == PRESC_MAX);

    // Phase is held (not zeroed) while paused so a partial second survives.
    always_comb begin
        presc_d = presc_q;
        if (clr_i) begin
            presc_d = '0;
        end else if (run_i) begin
            presc_d = at_max ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign tick_o = run_i & at_max;

endmodule : tick_prescaler

`default_nettype wire

// File: rtl/timer_ctrl.sv
// ============================================================================
// Module : timer_ctrl
// Brief  : Run/pause/clear sequencer and 1 Hz enable generator for a 59:59 BCD chain.
//          Optional lap capture is built when TIMER_LAP_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int LAP_W    = LAP_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    timer_ctrl_if.slave  ctrl_if
);

    timer_state_t state_q;
    timer_state_t state_d;
    logic         tick;
    logic         sec_en;
    logic         in_run;

    assign in_run = (state_q == RUN);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk    (clk),
        .rst    (rst),
        .run_i  (in_run),
        .clr_i  (ctrl_if.clear),
        .tick_o (tick)
    );

    assign sec_en = tick & ~ctrl_if.clear;

    always_comb begin
        state_d = state_q;
        if (ctrl_if.clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:  if (ctrl_if.start_stop) state_d = RUN;
                // The 59:59 wrap wins over a simultaneous pause request.
                RUN: begin
                    if (sec_en && ctrl_if.min_tc) begin
                        state_d = OVF;
                    end else if (ctrl_if.start_stop) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: if (ctrl_if.start_stop) state_d = RUN;
                OVF:   state_d = OVF;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign ctrl_if.sec_en  = sec_en;
    assign ctrl_if.min_en  = sec_en & ctrl_if.sec_tc;
    assign ctrl_if.cnt_clr = ctrl_if.clear;
    assign ctrl_if.running = in_run;
    assign ctrl_if.ovf     = (state_q == OVF);

`ifdef TIMER_LAP_EN
    logic             lap_hold_q;
    logic             lap_hold_d;
    logic [LAP_W-1:0] lap_cnt_q;
    logic [LAP_W-1:0] lap_cnt_d;

    always_comb begin
        lap_hold_d = lap_hold_q;
        lap_cnt_d  = lap_cnt_q;
        if (ctrl_if.clear) begin
            lap_hold_d = 1'b0;
            lap_cnt_d  = '0;
        end else if (ctrl_if.lap && (state_q == RUN || state_q == PAUSE)) begin
            lap_hold_d = ~lap_hold_q;
            // Only freezing the display counts as a lap; releasing it does not.
            if (!lap_hold_q && (lap_cnt_q != '1)) begin
                lap_cnt_d = lap_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_hold_q <= 1'b0;
            lap_cnt_q  <= '0;
        end else begin
            lap_hold_q <= lap_hold_d;
            lap_cnt_q  <= lap_cnt_d;
        end
    end

    assign ctrl_if.lap_hold = lap_hold_q;
    assign ctrl_if.lap_cnt  = lap_cnt_q;
`else
    logic lap_unused;
    assign lap_unused       = ctrl_if.lap;
    assign ctrl_if.lap_hold = 1'b0;
    assign ctrl_if.lap_cnt  = '0;
`endif

endmodule : timer_ctrl

`default_nettype wire

// File: tb/tb_timer_ctrl.sv
// ============================================================================
// Module : tb_timer_ctrl
// Brief  : Self-checking bench for timer_ctrl (TICK_DIV=4): vector table, hand
//          sequences for reset/lap corners, and random traffic against a model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_timer_ctrl;

    localparam int TICK_DIV = 4;
    localparam int LAP_W    = 4;
    localparam int LAP_MAX  = (1 << LAP_W) - 1;
`ifdef TIMER_LAP_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif

    localparam int M_IDLE  = 10;
    localparam int M_RUN   = 11;
    localparam int M_PAUSE = 12;
    localparam int M_OVF   = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    timer_ctrl_if #(.LAP_W(LAP_W)) bus ();

    timer_ctrl #(
        .TICK_DIV (TICK_DIV),
        .LAP_W    (LAP_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_if (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    int m_mode;
    int m_ph;
    int m_hold;
    int m_laps;

    typedef struct packed {
        logic ss, cl, st, mt;
        logic e_sec, e_min, e_clr, e_run, e_ovf;
    } vec_t;

    vec_t tbl [28];

    function automatic vec_t mk(input int ss, cl, st, mt, es, em, ec, er, eo);
        vec_t v;
        v.ss = ss[0]; v.cl = cl[0]; v.st = st[0]; v.mt = mt[0];
        v.e_sec = es[0]; v.e_min = em[0]; v.e_clr = ec[0]; v.e_run = er[0]; v.e_ovf = eo[0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ss, cl, st, mt, lp);
        bus.start_stop = ss;
        bus.clear      = cl;
        bus.sec_tc     = st;
        bus.min_tc     = mt;
        bus.lap        = lp;
    endtask

    task automatic check_all(input string tag, input int es, em, ec, er, eo, eh, el);
        chk({tag, ".sec_en"},   32'(bus.sec_en),   es);
        chk({tag, ".min_en"},   32'(bus.min_en),   em);
        chk({tag, ".cnt_clr"},  32'(bus.cnt_clr),  ec);
        chk({tag, ".running"},  32'(bus.running),  er);
        chk({tag, ".ovf"},      32'(bus.ovf),      eo);
        chk({tag, ".lap_hold"}, 32'(bus.lap_hold), eh);
        chk({tag, ".lap_cnt"},  32'(bus.lap_cnt),  el);
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_ph   = 0;
        m_hold = 0;
        m_laps = 0;
    endtask

    // Predicts this cycle's outputs from the model, compares, then advances the model.
    task automatic model_cycle(input string tag, input logic ss, cl, st, mt, lp);
        int es;
        es = (m_mode == M_RUN && m_ph == TICK_DIV - 1 && !cl) ? 1 : 0;
        check_all(tag, es, es & int'(st), int'(cl), (m_mode == M_RUN) ? 1 : 0,
                  (m_mode == M_OVF) ? 1 : 0, m_hold, m_laps);
        if (cl) begin
            model_reset();
        end else begin
            if (LAP_ON && lp && (m_mode == M_RUN || m_mode == M_PAUSE)) begin
                if (m_hold == 0) m_laps = (m_laps < LAP_MAX) ? m_laps + 1 : LAP_MAX;
                m_hold = 1 - m_hold;
            end
            if (m_mode == M_RUN) m_ph = (m_ph + 1) % TICK_DIV;
            case (m_mode)
                M_IDLE:  if (ss) m_mode = M_RUN;
                M_RUN:   if (es == 1 && mt) m_mode = M_OVF; else if (ss) m_mode = M_PAUSE;
                M_PAUSE: if (ss) m_mode = M_RUN;
                default: ;
            endcase
        end
    endtask

    task automatic step(input string tag, input logic ss, cl, st, mt, lp);
        drive(ss, cl, st, mt, lp);
        @(negedge clk);
        model_cycle(tag, ss, cl, st, mt, lp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        //             ss cl st mt  sec min clr run ovf
        tbl[0]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0,  0, 0, 0, 1, 0);
        tbl[3]  = mk(0, 0, 1, 0,  0, 0, 0, 1, 0);
        tbl[4]  = mk(0, 0, 0, 0,  0, 0, 0, 1, 0);
        tbl[5]  = mk(0, 0, 1, 0,  1, 1, 0, 1, 0);
        tbl[6]  = mk(0, 0, 0, 0,  0, 0, 0, 1, 0);
        tbl[7]  = mk(1, 0, 0, 0,  0, 0, 0, 1, 0);
        tbl[8]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 1, 0,  0, 0, 0, 0, 0);
        tbl[10] = mk(1, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 0, 0,  0, 0, 0, 1, 0);
        tbl[12] = mk(0, 0, 0, 1,  1, 0, 0, 1, 0);
        tbl[13] = mk(1, 0, 0, 0,  0, 0, 0, 0, 1);
        tbl[14] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1);
        tbl[15] = mk(0, 1, 0, 0,  0, 0, 1, 0, 1);
        tbl[16] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[17] = mk(1, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[18] = mk(0, 0, 0, 0,  0, 0, 0, 1, 0);
        tbl[19] = mk(0, 0, 0, 0,  0, 0, 0, 1, 0);
        tbl[20] = mk(0, 0, 0, 0,  0, 0, 0, 1, 0);
        tbl[21] = mk(1, 1, 1, 1,  0, 0, 1, 1, 0);
        tbl[22] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[23] = mk(1, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[24] = mk(0, 0, 0, 0,  0, 0, 0, 1, 0);
        tbl[25] = mk(0, 0, 0, 0,  0, 0, 0, 1, 0);
        tbl[26] = mk(0, 0, 0, 0,  0, 0, 0, 1, 0);
        tbl[27] = mk(0, 0, 0, 0,  1, 0, 0, 1, 0);

        drive(0, 0, 0, 0, 0);
        #2;
        do_reset();

        for (int i = 0; i < 28; i++) begin
            drive(tbl[i].ss, tbl[i].cl, tbl[i].st, tbl[i].mt, 1'b0);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), int'(tbl[i].e_sec), int'(tbl[i].e_min),
                      int'(tbl[i].e_clr), int'(tbl[i].e_run), int'(tbl[i].e_ovf), 0, 0);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in mid-run must drop running before any clock edge.
        do_reset();
        step("pre_arst", 1, 0, 0, 0, 0);
        step("pre_arst", 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.running", 32'(bus.running), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step("post_arst", 0, 0, 0, 0, 0);

        // Lap sequence: enough pulses in RUN to reach saturation.
        step("lap_start", 1, 0, 0, 0, 0);
        for (int k = 1; k <= 32; k++) begin
            drive(0, 0, 0, 0, 1);
            @(posedge clk);
            #1;
            drive(0, 0, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("lap%0d.hold", k), 32'(bus.lap_hold), LAP_ON ? (k % 2) : 0);
            chk($sformatf("lap%0d.cnt", k), 32'(bus.lap_cnt),
                LAP_ON ? (((k + 1) / 2 > LAP_MAX) ? LAP_MAX : (k + 1) / 2) : 0);
            @(posedge clk);
            #1;
        end
        drive(0, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lap_clr.hold", 32'(bus.lap_hold), 0);
        chk("lap_clr.cnt",  32'(bus.lap_cnt),  0);
        @(posedge clk);
        #1;

        // Random traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            step("rand",
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 4) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_timer_ctrl

`default_nettype wire
